reg_file_rename: RTL and testbench

//  Architectural register file with rename tags. Sits between the decoder and the commit port of the reorder buffer.
//  - Issue side: records which ROB entry will produce each destination register.
//  - Commit side: consumes the reorder buffer's commit stream (reg_write/reg_rd/reg_val/commit_rob_pos) and retires values.
//  - Answers two decoder operand queries per cycle with value, busy flag and producer ROB position.
//  - On rollback, discards all speculative rename state.

---
 rtl/reg_file_rename_if.sv | 46 ++++
 rtl/reg_file_rename.sv | 81 ++++++++
 tb/tb_reg_file_rename.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_rename_if.sv
// Decoder / reorder-buffer side bundle for reg_file_rename.
//   master : driven by the surrounding pipeline (decoder issue, ROB commit,
//            rollback, global rdy, operand query indices); reads query answers.
//   slave  : the register file itself.
// Signals:
//   rdy, rollback                     global enable / mispredict flush
//   issue, issue_rd, issue_rob_pos    rename a destination to a ROB entry
//   reg_write, reg_rd, reg_val,
//   commit_rob_pos                    commit stream from the ROB
//   rs1/rs2                           query indices
//   rsN_val, rsN_busy, rsN_rob_pos    query answers (combinational)
interface reg_file_rename_if #(
  parameter int REG_POS_W = 5,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
);
  logic                 rdy;
  logic                 rollback;
  logic                 issue;
  logic [REG_POS_W-1:0] issue_rd;
  logic [ROB_POS_W-1:0] issue_rob_pos;
  logic                 reg_write;
  logic [REG_POS_W-1:0] reg_rd;
  logic [DATA_W-1:0]    reg_val;
  logic [ROB_POS_W-1:0] commit_rob_pos;
  logic [REG_POS_W-1:0] rs1;
  logic [REG_POS_W-1:0] rs2;
  logic [DATA_W-1:0]    rs1_val;
  logic [DATA_W-1:0]    rs2_val;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [ROB_POS_W-1:0] rs1_rob_pos;
  logic [ROB_POS_W-1:0] rs2_rob_pos;

  modport master (
    output rdy, rollback, issue, issue_rd, issue_rob_pos,
    output reg_write, reg_rd, reg_val, commit_rob_pos, rs1, rs2,
    input  rs1_val, rs1_busy, rs1_rob_pos, rs2_val, rs2_busy, rs2_rob_pos
  );

  modport slave (
    input  rdy, rollback, issue, issue_rd, issue_rob_pos,
    input  reg_write, reg_rd, reg_val, commit_rob_pos, rs1, rs2,
    output rs1_val, rs1_busy, rs1_rob_pos, rs2_val, rs2_busy, rs2_rob_pos
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with rename tags.
// Tracks, per architectural register, the committed value, whether a newer
// value is still pending in the reorder buffer, and which ROB entry will
// produce it. Answers two operand queries per cycle, with a same-cycle bypass
// for a commit that retires the pending producer of the queried register.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset (clears all values, busy bits, tags)
//   rf   reg_file_rename_if.slave (issue, commit, rollback, rdy, queries)
module reg_file_rename #(
  parameter int REG_NUM   = 32,
  parameter int REG_POS_W = 5,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_rename_if.slave      rf
);

  logic [DATA_W-1:0]    val_r [REG_NUM];
  logic [ROB_POS_W-1:0] tag_r [REG_NUM];
  logic [REG_NUM-1:0]   busy_r;

  // Commit retires the pending producer only when the tag still matches;
  // a mismatch means a younger instruction (WAW) has renamed the register.
  logic commit_clr;
  assign commit_clr = rf.reg_write && busy_r[rf.reg_rd] &&
                      (tag_r[rf.reg_rd] == rf.commit_rob_pos);

  // Register 0 is never touched after reset, so it stays 0 / not busy / tag 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        val_r[r]  <= '0;
        tag_r[r]  <= '0;
        busy_r[r] <= 1'b0;
      end
    end else if (rf.rdy) begin
      for (int r = 1; r < REG_NUM; r++) begin
        // Committed value lands even on a rollback cycle.
        if (rf.reg_write && (rf.reg_rd == REG_POS_W'(r)))
          val_r[r] <= rf.reg_val;
        // Priority: rollback flush > new issue > matching commit clear.
        if (rf.rollback) begin
          busy_r[r] <= 1'b0;
        end else if (rf.issue && (rf.issue_rd == REG_POS_W'(r))) begin
          busy_r[r] <= 1'b1;
          tag_r[r]  <= rf.issue_rob_pos;
        end else if (commit_clr && (rf.reg_rd == REG_POS_W'(r))) begin
          busy_r[r] <= 1'b0;
        end
      end
    end
  end

  // Same-cycle commit bypass; frozen state (rdy=0) ignores the commit stream.
  logic hit1, hit2;
  assign hit1 = rf.rdy && rf.reg_write && (rf.rs1 != '0) && (rf.reg_rd == rf.rs1) &&
                busy_r[rf.rs1] && (tag_r[rf.rs1] == rf.commit_rob_pos);
  assign hit2 = rf.rdy && rf.reg_write && (rf.rs2 != '0) && (rf.reg_rd == rf.rs2) &&
                busy_r[rf.rs2] && (tag_r[rf.rs2] == rf.commit_rob_pos);

  always_comb begin
    rf.rs1_val     = val_r[rf.rs1];
    rf.rs1_busy    = busy_r[rf.rs1];
    rf.rs1_rob_pos = tag_r[rf.rs1];
    rf.rs2_val     = val_r[rf.rs2];
    rf.rs2_busy    = busy_r[rf.rs2];
    rf.rs2_rob_pos = tag_r[rf.rs2];
    if (hit1) begin
      rf.rs1_val  = rf.reg_val;
      rf.rs1_busy = 1'b0;
    end
    if (hit2) begin
      rf.rs2_val  = rf.reg_val;
      rf.rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
module tb_reg_file_rename;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_rename_if #(.REG_POS_W(5), .ROB_POS_W(4), .DATA_W(32)) rf_if ();

  reg_file_rename #(.REG_NUM(32), .REG_POS_W(5), .ROB_POS_W(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  typedef struct {
    string       name;
    logic [31:0] v;
    logic        b;
    logic [3:0]  p;
    bit          chk_p;
  } exp_t;

  typedef struct {
    bit          rdy, rb, iss;
    int          ird, ipos;
    bit          rw;
    int          rd;
    logic [31:0] rv;
    int          cp, q1, q2;
    bit          smp;
    exp_t        e1, e2;
  } row_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // Stimulus row: rdy rollback issue issue_rd issue_pos | reg_write reg_rd reg_val commit_pos |
  // rs1 rs2 sample | rs1 expect (val busy pos chk_pos) | rs2 expect (val busy pos chk_pos)
  function automatic row_t row(string nm, bit rdy, bit rb, bit iss, int ird, int ipos,
                               bit rw, int rd, logic [31:0] rv, int cp, int q1, int q2, bit smp,
                               logic [31:0] v1, bit b1, int p1, bit c1,
                               logic [31:0] v2, bit b2, int p2, bit c2);
    row_t x;
    x.rdy = rdy; x.rb = rb; x.iss = iss; x.ird = ird; x.ipos = ipos;
    x.rw = rw; x.rd = rd; x.rv = rv; x.cp = cp; x.q1 = q1; x.q2 = q2; x.smp = smp;
    x.e1.name = nm; x.e1.v = v1; x.e1.b = b1; x.e1.p = 4'(p1); x.e1.chk_p = c1;
    x.e2.name = nm; x.e2.v = v2; x.e2.b = b2; x.e2.p = 4'(p2); x.e2.chk_p = c2;
    return x;
  endfunction

  task automatic apply(input row_t x);
    rf_if.rdy = x.rdy; rf_if.rollback = x.rb; rf_if.issue = x.iss;
    rf_if.issue_rd = 5'(x.ird); rf_if.issue_rob_pos = 4'(x.ipos);
    rf_if.reg_write = x.rw; rf_if.reg_rd = 5'(x.rd); rf_if.reg_val = x.rv;
    rf_if.commit_rob_pos = 4'(x.cp); rf_if.rs1 = 5'(x.q1); rf_if.rs2 = 5'(x.q2);
    if (x.smp) begin
      sb_q.push_back(x.e1);
      sb_q.push_back(x.e2);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] gv; logic gb; logic [3:0] gp;
    rst = 1'b0;
    apply(row("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    #3;
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      gv = k ? rf_if.rs2_val : rf_if.rs1_val;
      gb = k ? rf_if.rs2_busy : rf_if.rs1_busy;
      gp = k ? rf_if.rs2_rob_pos : rf_if.rs1_rob_pos;
      checks++; if (gv !== e.v) begin failures++; $display("FAIL %s rs%0d_val got=%h want=%h", e.name, k+1, gv, e.v); end
      checks++; if (gb !== e.b) begin failures++; $display("FAIL %s rs%0d_busy got=%b want=%b", e.name, k+1, gb, e.b); end
      if (e.chk_p) begin checks++; if (gp !== e.p) begin failures++; $display("FAIL %s rs%0d_rob_pos got=%0d want=%0d", e.name, k+1, gp, e.p); end end
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_issue_commit();
    row_t rows[$];
    exp_t e;
    logic [31:0] gv; logic gb; logic [3:0] gp;
    rows.push_back(row("ic_issue",  1, 0, 1, 5, 3, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("ic_busy",   1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 1, 3, 1, 0, 0, 0, 1));
    rows.push_back(row("ic_bypass", 1, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 3, 5, 0, 1, 32'hDEADBEEF, 0, 3, 1, 0, 0, 0, 1));
    rows.push_back(row("ic_held",   1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 32'hDEADBEEF, 0, 3, 1, 0, 0, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      if (rows[i].smp) begin
        for (int k = 0; k < 2; k++) begin
          e = sb_q.pop_front();
          gv = k ? rf_if.rs2_val : rf_if.rs1_val;
          gb = k ? rf_if.rs2_busy : rf_if.rs1_busy;
          gp = k ? rf_if.rs2_rob_pos : rf_if.rs1_rob_pos;
          checks++; if (gv !== e.v) begin failures++; $display("FAIL %s rs%0d_val got=%h want=%h", e.name, k+1, gv, e.v); end
          checks++; if (gb !== e.b) begin failures++; $display("FAIL %s rs%0d_busy got=%b want=%b", e.name, k+1, gb, e.b); end
          if (e.chk_p) begin checks++; if (gp !== e.p) begin failures++; $display("FAIL %s rs%0d_rob_pos got=%0d want=%0d", e.name, k+1, gp, e.p); end end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_waw();
    row_t rows[$];
    exp_t e;
    logic [31:0] gv; logic gb; logic [3:0] gp;
    rows.push_back(row("waw_i3",    1, 0, 1, 5, 3, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("waw_i7",    1, 0, 1, 5, 7, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("waw_cmt",   1, 0, 0, 0, 0, 1, 5, 32'h11, 3, 5, 0, 1, 32'hDEADBEEF, 1, 7, 1, 0, 0, 0, 1));
    rows.push_back(row("waw_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 32'h11, 1, 7, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      if (rows[i].smp) begin
        for (int k = 0; k < 2; k++) begin
          e = sb_q.pop_front();
          gv = k ? rf_if.rs2_val : rf_if.rs1_val;
          gb = k ? rf_if.rs2_busy : rf_if.rs1_busy;
          gp = k ? rf_if.rs2_rob_pos : rf_if.rs1_rob_pos;
          checks++; if (gv !== e.v) begin failures++; $display("FAIL %s rs%0d_val got=%h want=%h", e.name, k+1, gv, e.v); end
          checks++; if (gb !== e.b) begin failures++; $display("FAIL %s rs%0d_busy got=%b want=%b", e.name, k+1, gb, e.b); end
          if (e.chk_p) begin checks++; if (gp !== e.p) begin failures++; $display("FAIL %s rs%0d_rob_pos got=%0d want=%0d", e.name, k+1, gp, e.p); end end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_same_edge();
    row_t rows[$];
    exp_t e;
    logic [31:0] gv; logic gb; logic [3:0] gp;
    rows.push_back(row("se_i2",    1, 0, 1, 6, 2, 0, 0, 0, 0, 6, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("se_both",  1, 0, 1, 6, 9, 1, 6, 32'hA5A50006, 2, 6, 5, 1, 32'hA5A50006, 0, 2, 1, 32'h11, 1, 7, 1));
    rows.push_back(row("se_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 5, 1, 32'hA5A50006, 1, 9, 1, 32'h11, 1, 7, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      if (rows[i].smp) begin
        for (int k = 0; k < 2; k++) begin
          e = sb_q.pop_front();
          gv = k ? rf_if.rs2_val : rf_if.rs1_val;
          gb = k ? rf_if.rs2_busy : rf_if.rs1_busy;
          gp = k ? rf_if.rs2_rob_pos : rf_if.rs1_rob_pos;
          checks++; if (gv !== e.v) begin failures++; $display("FAIL %s rs%0d_val got=%h want=%h", e.name, k+1, gv, e.v); end
          checks++; if (gb !== e.b) begin failures++; $display("FAIL %s rs%0d_busy got=%b want=%b", e.name, k+1, gb, e.b); end
          if (e.chk_p) begin checks++; if (gp !== e.p) begin failures++; $display("FAIL %s rs%0d_rob_pos got=%0d want=%0d", e.name, k+1, gp, e.p); end end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0();
    row_t rows[$];
    exp_t e;
    logic [31:0] gv; logic gb; logic [3:0] gp;
    rows.push_back(row("x0_drive", 1, 0, 1, 0, 1, 1, 0, 32'h55, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    rows.push_back(row("x0_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      if (rows[i].smp) begin
        for (int k = 0; k < 2; k++) begin
          e = sb_q.pop_front();
          gv = k ? rf_if.rs2_val : rf_if.rs1_val;
          gb = k ? rf_if.rs2_busy : rf_if.rs1_busy;
          gp = k ? rf_if.rs2_rob_pos : rf_if.rs1_rob_pos;
          checks++; if (gv !== e.v) begin failures++; $display("FAIL %s rs%0d_val got=%h want=%h", e.name, k+1, gv, e.v); end
          checks++; if (gb !== e.b) begin failures++; $display("FAIL %s rs%0d_busy got=%b want=%b", e.name, k+1, gb, e.b); end
          if (e.chk_p) begin checks++; if (gp !== e.p) begin failures++; $display("FAIL %s rs%0d_rob_pos got=%0d want=%0d", e.name, k+1, gp, e.p); end end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rollback();
    row_t rows[$];
    exp_t e;
    logic [31:0] gv; logic gb; logic [3:0] gp;
    rows.push_back(row("rb_i3", 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("rb_i4", 1, 0, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("rb_i5", 1, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("rb_cyc", 1, 1, 1, 7, 2, 1, 4, 32'h77, 4, 4, 5, 1, 32'h77, 0, 4, 1, 32'h11, 1, 5, 1));
    rows.push_back(row("rb_45",  1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 1, 32'h77, 0, 0, 0, 32'h11, 0, 0, 0));
    rows.push_back(row("rb_37",  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("fz_i3", 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("fz_i4", 1, 0, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("fz_i5", 1, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("fz_cyc", 0, 1, 1, 7, 2, 1, 4, 32'h88, 4, 4, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row("fz_47",  1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 7, 1, 32'h77, 1, 4, 1, 0, 0, 0, 0));
    rows.push_back(row("fz_53",  1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 3, 1, 32'h11, 1, 5, 1, 0, 1, 1, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      if (rows[i].smp) begin
        for (int k = 0; k < 2; k++) begin
          e = sb_q.pop_front();
          gv = k ? rf_if.rs2_val : rf_if.rs1_val;
          gb = k ? rf_if.rs2_busy : rf_if.rs1_busy;
          gp = k ? rf_if.rs2_rob_pos : rf_if.rs1_rob_pos;
          checks++; if (gv !== e.v) begin failures++; $display("FAIL %s rs%0d_val got=%h want=%h", e.name, k+1, gv, e.v); end
          checks++; if (gb !== e.b) begin failures++; $display("FAIL %s rs%0d_busy got=%b want=%b", e.name, k+1, gb, e.b); end
          if (e.chk_p) begin checks++; if (gp !== e.p) begin failures++; $display("FAIL %s rs%0d_rob_pos got=%0d want=%0d", e.name, k+1, gp, e.p); end end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] gv; logic gb; logic [3:0] gp;
    apply(row("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      gv = k ? rf_if.rs2_val : rf_if.rs1_val;
      gb = k ? rf_if.rs2_busy : rf_if.rs1_busy;
      gp = k ? rf_if.rs2_rob_pos : rf_if.rs1_rob_pos;
      checks++; if (gv !== e.v) begin failures++; $display("FAIL %s rs%0d_val got=%h want=%h", e.name, k+1, gv, e.v); end
      checks++; if (gb !== e.b) begin failures++; $display("FAIL %s rs%0d_busy got=%b want=%b", e.name, k+1, gb, e.b); end
      if (e.chk_p) begin checks++; if (gp !== e.p) begin failures++; $display("FAIL %s rs%0d_rob_pos got=%0d want=%0d", e.name, k+1, gp, e.p); end end
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Randomised traffic on registers 0..7 against a behavioural model that starts
  // from the empty post-reset state.
  task automatic test_random();
    logic [31:0] mv [8];
    logic        mb [8];
    logic [3:0]  mt [8];
    row_t x;
    exp_t e;
    logic [31:0] gv; logic gb; logic [3:0] gp;
    int qs [2];
    for (int r = 0; r < 8; r++) begin mv[r] = '0; mb[r] = 1'b0; mt[r] = '0; end
    for (int n = 0; n < 300; n++) begin
      x = row("rnd", ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom_range(0, 15),
              ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom, 0,
              $urandom_range(0, 7), $urandom_range(0, 7), 1, 0, 0, 0, 0, 0, 0, 0, 0);
      x.cp = ($urandom_range(0, 1) == 1) ? int'(mt[x.rd]) : $urandom_range(0, 15);
      x.smp = x.rdy;
      qs[0] = x.q1; qs[1] = x.q2;
      for (int k = 0; k < 2; k++) begin
        e.name = "rnd"; e.v = mv[qs[k]]; e.b = mb[qs[k]]; e.p = mt[qs[k]];
        if (x.rw && x.rd == qs[k] && qs[k] != 0 && mb[qs[k]] && mt[qs[k]] == 4'(x.cp)) begin
          e.v = x.rv; e.b = 1'b0;
        end
        e.chk_p = mb[qs[k]];
        if (k == 0) x.e1 = e; else x.e2 = e;
      end
      apply(x);
      @(negedge clk);
      if (x.smp) begin
        for (int k = 0; k < 2; k++) begin
          e = sb_q.pop_front();
          gv = k ? rf_if.rs2_val : rf_if.rs1_val;
          gb = k ? rf_if.rs2_busy : rf_if.rs1_busy;
          gp = k ? rf_if.rs2_rob_pos : rf_if.rs1_rob_pos;
          checks++; if (gv !== e.v) begin failures++; $display("FAIL %s%0d rs%0d_val got=%h want=%h", e.name, n, k+1, gv, e.v); end
          checks++; if (gb !== e.b) begin failures++; $display("FAIL %s%0d rs%0d_busy got=%b want=%b", e.name, n, k+1, gb, e.b); end
          if (e.chk_p) begin checks++; if (gp !== e.p) begin failures++; $display("FAIL %s%0d rs%0d_rob_pos got=%0d want=%0d", e.name, n, k+1, gp, e.p); end end
        end
      end
      if (x.rdy) begin
        if (x.rw && x.rd != 0) begin
          if (mb[x.rd] && mt[x.rd] == 4'(x.cp)) mb[x.rd] = 1'b0;
          mv[x.rd] = x.rv;
        end
        if (x.iss && x.ird != 0 && !x.rb) begin mb[x.ird] = 1'b1; mt[x.ird] = 4'(x.ipos); end
        if (x.rb) for (int r = 0; r < 8; r++) mb[r] = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_issue_commit();
    test_waw();
    test_same_edge();
    test_x0();
    test_rollback();
    test_reset_mid();
    test_random();
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
